dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; DBG_MAX_WAIT, default 8, max consecutive CPU grants while debug waits.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports as listed in REQ-003 to REQ-020.
REQ-003 SHALL have clk_i  in  1  clock, all logic on rising edge.
REQ-004 SHALL have rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have cpu_req_i  in  1  MEM-stage access request, held while stalled.
REQ-006 SHALL have cpu_we_i  in  1  1=write, 0=read.
REQ-007 SHALL have cpu_addr_i  in  ADDR_W  CPU byte address.
REQ-008 SHALL have cpu_wdata_i  in  DATA_W  CPU store data.
REQ-009 SHALL have cpu_rdata_o  out  DATA_W  CPU load data, registered.
REQ-010 SHALL have cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM.
REQ-011 SHALL have dbg_req_i  in  1  debug/loader request, held until dbg_ack_o.
REQ-012 SHALL have dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/ADDR_W/DATA_W  debug command.
REQ-013 SHALL have dbg_rdata_o  out  DATA_W  debug read data, registered.
REQ-014 SHALL have dbg_ack_o  out  1  one-cycle completion pulse.
REQ-015 SHALL have mem_req_o  out  1  memory request.
REQ-016 SHALL have mem_we_o  out  1  memory write enable.
REQ-017 SHALL have mem_addr_o  out  ADDR_W  memory address.
REQ-018 SHALL have mem_wdata_o  out  DATA_W  memory write data.
REQ-019 SHALL have mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
REQ-020 SHALL have mem_ack_i  in  1  transfer complete, any latency >=0 wait cycles.

Function
REQ-021 SHALL implement FSM states IDLE, CPU_XFER, CPU_DONE, DBG_XFER, DBG_DONE.
REQ-022 IDLE SHALL grant the CPU and go to CPU_XFER if cpu_req_i=1 and (dbg_req_i=0 or starve_cnt<DBG_MAX_WAIT).
REQ-023 IDLE SHALL otherwise grant debug and go to DBG_XFER if dbg_req_i=1; with no request it SHALL stay in IDLE.
REQ-024 On grant, SHALL latch we/addr/wdata of the winner into mem_*_o registers.
REQ-025 mem_req_o SHALL be 1 exactly in XFER states; mem_we_o/addr/wdata SHALL stay stable while mem_req_o=1.
REQ-026 XFER SHALL stay put until mem_ack_i=1, then go to the matching DONE state.
REQ-027 On a read ack, SHALL load mem_rdata_i into cpu_rdata_o or dbg_rdata_o; writes SHALL leave rdata registers unchanged.
REQ-028 mem_ack_i SHALL be ignored outside XFER states.
REQ-029 cpu_stall_o SHALL equal cpu_req_i AND state!=CPU_DONE, combinationally; minimum CPU access SHALL be 2 stall cycles (ack in first XFER cycle).
REQ-030 dbg_ack_o SHALL be 1 only in DBG_DONE.
REQ-031 Both DONE states SHALL return to IDLE unconditionally; no grant is issued from DONE.
REQ-032 starve_cnt (width clog2(DBG_MAX_WAIT+1)) SHALL increment, saturating at DBG_MAX_WAIT, on each CPU grant with dbg_req_i=1.
REQ-033 starve_cnt SHALL clear on each debug grant.
REQ-034 Requests arriving during XFER/DONE SHALL wait; requester inputs SHALL not affect latched transfer.

Reset
REQ-035 rst_i=1 at any edge, including mid-XFER, SHALL force IDLE, starve_cnt=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0, dbg_rdata_o=0.
REQ-036 While rst_i=1, cpu_stall_o and dbg_ack_o SHALL be 0; an abandoned memory transfer is not retried.

Structure
REQ-037 State encoding and DBG_MAX_WAIT default SHALL live in shared package dmem_arb_pkg.
REQ-038 The saturating starvation counter SHALL be sub-module starve_counter; all else lives in dmem_arbiter.

Verification
REQ-039 CPU read addr 0x40 alone, ack in first XFER cycle with 0xDEADBEEF -> mem_req_o cycle 1, stall high cycles 0-1, low cycle 2, cpu_rdata_o=0xDEADBEEF.
REQ-040 ack delayed 3 cycles -> mem_req_o high 4 cycles, mem_addr_o/mem_wdata_o constant, cpu_stall_o high throughout.
REQ-041 cpu and dbg both request at cycle 0, starve_cnt=0 -> CPU first, debug granted on next IDLE, dbg_ack_o single pulse.
REQ-042 dbg_req_i held, CPU back-to-back, DBG_MAX_WAIT=8 -> grants 1-8 to CPU, grant 9 to debug, starve_cnt back to 0.
REQ-043 debug write 0x100 <- 0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678, dbg_rdata_o unchanged.
REQ-044 rst_i pulsed in CPU_XFER -> next cycle mem_req_o=0, cpu_stall_o=0 during reset, then fresh request serviced normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and the
// default debug starvation limit.
package dmem_arb_pkg;

    localparam int DBG_MAX_WAIT_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_XFER = 3'd1,
        CPU_DONE = 3'd2,
        DBG_XFER = 3'd3,
        DBG_DONE = 3'd4
    } arb_state_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of CPU grants taken while the debug port was waiting.
// Clear has priority over increment.
module starve_counter #(
    parameter int MAX   = 8,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one data-memory port between the CPU MEM stage and a debug/loader
// master. CPU wins unless debug has already waited DBG_MAX_WAIT CPU grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DBG_MAX_WAIT);

    arb_state_e        state_d,     state_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_d, dbg_rdata_q;
    logic              starve_inc;
    logic              starve_clr;
    logic [CNT_W-1:0]  starve_cnt;

    starve_counter #(
        .MAX   (DBG_MAX_WAIT),
        .CNT_W (CNT_W)
    ) u_starve_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .cnt_o (starve_cnt)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && (!dbg_req_i || (starve_cnt < MAX_CNT))) begin
                    state_d     = CPU_XFER;
                    mem_we_d    = cpu_we_i;
                    mem_addr_d  = cpu_addr_i;
                    mem_wdata_d = cpu_wdata_i;
                    starve_inc  = dbg_req_i;
                end else if (dbg_req_i) begin
                    state_d     = DBG_XFER;
                    mem_we_d    = dbg_we_i;
                    mem_addr_d  = dbg_addr_i;
                    mem_wdata_d = dbg_wdata_i;
                    starve_clr  = 1'b1;
                end
            end
            CPU_XFER: begin
                if (mem_ack_i) begin
                    state_d = CPU_DONE;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata_i;
                    end
                end
            end
            DBG_XFER: begin
                if (mem_ack_i) begin
                    state_d = DBG_DONE;
                    if (!mem_we_q) begin
                        dbg_rdata_d = mem_rdata_i;
                    end
                end
            end
            CPU_DONE: state_d = IDLE;
            DBG_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Stall drops only in the completion cycle, letting the pipeline advance once.
    assign cpu_stall_o = cpu_req_i && (state_q != CPU_DONE) && !rst_i;
    assign dbg_ack_o   = (state_q == DBG_DONE) && !rst_i;
    assign mem_req_o   = (state_q == CPU_XFER) || (state_q == DBG_XFER);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the two masters and the memory.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cpu_req_i, cpu_we_i, cpu_stall_o;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i, cpu_rdata_o;
    logic          dbg_req_i, dbg_we_i, dbg_ack_o;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_wdata_i, dbg_rdata_o;
    logic          mem_req_o, mem_we_o, mem_ack_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_ack_o   (dbg_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pending commands held by each master until completed.
    bit            cpu_act, dbg_act;
    logic          cpu_we_r, dbg_we_r;
    logic [AW-1:0] cpu_addr_r, dbg_addr_r;
    logic [DW-1:0] cpu_wdata_r, dbg_wdata_r;
    // Bus view: 0 = free, 1 = transfer in flight, 2 = completion cycle.
    int            phase;
    bit            own_dbg;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    int            wait_left;
    int            starve;
    logic [DW-1:0] exp_cpu_rd, exp_dbg_rd;
    logic [DW-1:0] exp_q[$];
    // Memory behaviour knobs.
    int            lat_cfg;
    bit            rd_cfg_en;
    logic [DW-1:0] rd_cfg;
    // Observed events.
    int            obs_cpu_done, obs_dbg_ack, obs_req_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_act = 1'b1; cpu_we_r = we; cpu_addr_r = a; cpu_wdata_r = d;
    endtask

    task automatic new_dbg(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_act = 1'b1; dbg_we_r = we; dbg_addr_r = a; dbg_wdata_r = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; cpu_req_i = 1'b1; dbg_req_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        chk("rst_stall", 32'(cpu_stall_o), 32'd0);
        chk("rst_dbg_ack", 32'(dbg_ack_o), 32'd0);
        @(posedge clk); #2;
        rst_i = 1'b0; cpu_req_i = 1'b0;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        phase = 0; starve = 0; cpu_act = 0; dbg_act = 0;
        exp_cpu_rd = '0; exp_dbg_rd = '0; exp_q.delete();
    endtask

    // One clock cycle: drive masters and memory, check outputs, advance model.
    task automatic step();
        logic [DW-1:0] rd;
        bit cpu_hold, dbg_hold;
        // Once granted, a master's command fields must no longer matter.
        cpu_hold = cpu_act && !(phase != 0 && !own_dbg);
        dbg_hold = dbg_act && !(phase != 0 && own_dbg);
        cpu_req_i   = cpu_act;
        cpu_we_i    = cpu_hold ? cpu_we_r : 1'($urandom_range(0, 1));
        cpu_addr_i  = cpu_hold ? cpu_addr_r : $urandom;
        cpu_wdata_i = cpu_hold ? cpu_wdata_r : $urandom;
        dbg_req_i   = dbg_act;
        dbg_we_i    = dbg_hold ? dbg_we_r : 1'($urandom_range(0, 1));
        dbg_addr_i  = dbg_hold ? dbg_addr_r : $urandom;
        dbg_wdata_i = dbg_hold ? dbg_wdata_r : $urandom;
        rd = rd_cfg_en ? rd_cfg : $urandom;
        mem_rdata_i = rd;
        mem_ack_i = (phase == 1) ? (wait_left == 0) : 1'($urandom_range(0, 1));
        #1;
        chk("stall", 32'(cpu_stall_o), 32'(cpu_act && !(phase == 2 && !own_dbg)));
        chk("mem_req", 32'(mem_req_o), 32'(phase == 1));
        chk("dbg_ack", 32'(dbg_ack_o), 32'(phase == 2 && own_dbg));
        if (phase == 1) begin
            chk("mem_we", 32'(mem_we_o), 32'(x_we));
            chk("mem_addr", mem_addr_o, x_addr);
            chk("mem_wdata", mem_wdata_o, x_wdata);
        end
        if (phase == 2 && !x_we) begin
            chk("read_queued", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                chk("read_data", own_dbg ? dbg_rdata_o : cpu_rdata_o, exp_q.pop_front());
            end
        end
        chk("cpu_rdata", cpu_rdata_o, exp_cpu_rd);
        chk("dbg_rdata", dbg_rdata_o, exp_dbg_rd);
        if (cpu_req_i && !cpu_stall_o) obs_cpu_done++;
        if (dbg_ack_o) obs_dbg_ack++;
        if (mem_req_o) obs_req_cycles++;
        case (phase)
            0: begin
                if (cpu_act && (!dbg_act || starve < MAXW)) begin
                    own_dbg = 1'b0; x_we = cpu_we_r; x_addr = cpu_addr_r; x_wdata = cpu_wdata_r;
                    if (dbg_act && starve < MAXW) starve++;
                    phase = 1;
                end else if (dbg_act) begin
                    own_dbg = 1'b1; x_we = dbg_we_r; x_addr = dbg_addr_r; x_wdata = dbg_wdata_r;
                    starve = 0;
                    phase = 1;
                end
                wait_left = (lat_cfg >= 0) ? lat_cfg : $urandom_range(0, 3);
            end
            1: begin
                if (mem_ack_i) begin
                    phase = 2;
                    if (!x_we) begin
                        exp_q.push_back(rd);
                        if (own_dbg) exp_dbg_rd = rd;
                        else         exp_cpu_rd = rd;
                    end
                end else begin
                    wait_left--;
                end
            end
            default: begin
                phase = 0;
                if (own_dbg) dbg_act = 0;
                else         cpu_act = 0;
            end
        endcase
        @(posedge clk); #2;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((cpu_act || dbg_act || phase != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(cpu_act || dbg_act || phase != 0), 32'd0);
    endtask

    task automatic rand_reqs();
        if (!cpu_act && $urandom_range(0, 2) != 0)
            new_cpu(1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)) << 2, $urandom);
        if (!dbg_act && $urandom_range(0, 3) == 0)
            new_dbg(1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)) << 2, $urandom);
    endtask

    initial begin
        logic [DW-1:0] dbg_prev;
        rst_i = 1'b1; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0;
        lat_cfg = -1; rd_cfg_en = 0; rd_cfg = '0;
        obs_cpu_done = 0; obs_dbg_ack = 0; obs_req_cycles = 0;
        phase = 0; own_dbg = 0; x_we = 0; x_addr = '0; x_wdata = '0; wait_left = 0;
        do_reset();

        // Single CPU read, zero-wait memory.
        lat_cfg = 0; rd_cfg_en = 1; rd_cfg = 32'hDEADBEEF;
        new_cpu(1'b0, 32'h40, 32'h0);
        step(); step(); step();
        chk("cpu_read_deadbeef", cpu_rdata_o, 32'hDEADBEEF);

        // Three wait states: request held for four cycles.
        lat_cfg = 3; rd_cfg = 32'hCAFEF00D; obs_req_cycles = 0;
        new_cpu(1'b0, 32'h80, 32'h0);
        drain(20);
        chk("slow_req_cycles", 32'(obs_req_cycles), 32'd4);
        chk("slow_read_data", cpu_rdata_o, 32'hCAFEF00D);

        // Simultaneous requests: CPU first, then a single debug ack.
        lat_cfg = -1; rd_cfg_en = 0; obs_dbg_ack = 0;
        new_cpu(1'b1, 32'h10, 32'hA5A5A5A5);
        new_dbg(1'b0, 32'h20, 32'h0);
        drain(30);
        chk("dual_dbg_ack_pulses", 32'(obs_dbg_ack), 32'd1);

        // Debug write must leave debug read data untouched.
        dbg_prev = exp_dbg_rd;
        new_dbg(1'b1, 32'h100, 32'h12345678);
        drain(20);
        chk("dbg_write_keeps_rdata", dbg_rdata_o, dbg_prev);

        // Starvation limit: eight CPU grants, then debug; twice in a row.
        do_reset();
        lat_cfg = 0;
        for (int rep = 0; rep < 2; rep++) begin
            new_dbg(1'b0, 32'h200 + 32'(rep * 4), 32'h0);
            obs_cpu_done = 0; obs_dbg_ack = 0;
            for (int n = 0; n < 200 && obs_dbg_ack == 0; n++) begin
                if (!cpu_act) new_cpu(1'b0, 32'h1000 + 32'(n * 4), 32'h0);
                step();
            end
            chk("starve_cpu_grants", 32'(obs_cpu_done), 32'(MAXW));
            chk("starve_dbg_ack", 32'(obs_dbg_ack), 32'd1);
        end
        cpu_act = cpu_act && (phase != 0);
        drain(20);

        // Reset in the middle of a CPU transfer, then a fresh read.
        lat_cfg = 6;
        new_cpu(1'b0, 32'h44, 32'h0);
        step(); step();
        do_reset();
        lat_cfg = 1; rd_cfg_en = 1; rd_cfg = 32'h0BADF00D;
        new_cpu(1'b0, 32'h48, 32'h0);
        drain(20);
        chk("post_reset_read", cpu_rdata_o, 32'h0BADF00D);

        // Random traffic from both masters with random memory latency.
        lat_cfg = -1; rd_cfg_en = 0;
        for (int i = 0; i < 600; i++) begin
            rand_reqs();
            step();
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
